seg7_ila_probe: RTL and testbench
=================================

SEG7_ILA_PROBE -- requirements
Module: seg7_ila_probe

Interface
REQ-001 Parameter FAULT_LIMIT, default 1024, SHALL set the illegal-anode-pattern cycle count at which the fault trigger asserts (range 1..65535).
REQ-002 One clock; reset is synchronous and active-high. Ports: clk input 1 (rising-edge clock for all state); rst input 1 (synchronous, active-high reset).
REQ-003 seg_an input 4: 7-segment anode selects, active-low, asynchronous to nothing (same clk domain).
REQ-004 seg_cat input 8: cathodes {dp,g..a}, same clk domain.
REQ-005 btn input 4: raw push-buttons, asynchronous.
REQ-006 data output 32: ILA capture word {ts[15:0], btn_s[3:0], an[3:0], cat[7:0]}.
REQ-007 trig0 output 32: ILA trigger vector, field map per REQ-013..REQ-018.

Function
REQ-008 seg_an/seg_cat SHALL be registered once (stage s1); data and trig0 SHALL be registered outputs (stage s2); a seg value present before edge N appears on data after edge N+1.
REQ-009 btn SHALL pass a 2-flop synchronizer (btn_s) before use; btn latency to data is one cycle more than seg.
REQ-010 ts SHALL be a 16-bit free-running counter, +1 every cycle, wrapping FFFF->0000; data[31:16] carries ts as of the s2 edge.
REQ-011 Change detect: chg = ({an_s1,cat_s1} != previous {an_s1,cat_s1}), evaluated every cycle.
REQ-012 Button edge: rise[i] = btn_s[i] & ~btn_s_prev[i].
REQ-013 trig0[0] SHALL be a one-cycle pulse aligned with the data word that differs from its predecessor.
REQ-014 trig0[1] SHALL equal OR of rise[3:0]; trig0[7:4] SHALL equal rise[3:0]; each a one-cycle pulse.
REQ-015 trig0[2] (scan fault): an_s1 legal iff exactly one bit 0 or all bits 1; illegal-run counter (16 bit, saturating) increments each illegal cycle, clears to 0 on a legal cycle; trig0[2] = (counter >= FAULT_LIMIT), level, deasserts the cycle after a legal pattern.
REQ-016 trig0[3] SHALL pulse one cycle exactly when data[31:16] steps FFFF->0000; never on the first word after reset.
REQ-017 trig0[15:8] SHALL be an 8-bit count of chg events, incremented with trig0[0], wrapping 255->0.
REQ-018 trig0[31:16] (scan period): digit-0 event = falling edge of an_s1[0]; period counter increments per cycle, saturates at FFFF, restarts at 1 on event; on each event after the first since reset, trig0[31:16] <= period counter value; first event only arms measurement; holds between events.
REQ-019 Simultaneous events (chg, rise, fault, wrap, digit-0) SHALL all be reported in the same word; no priority or suppression.

Reset
REQ-020 While rst=1 at an edge: data=0, trig0=0, ts=0, all s1/sync/prev registers=0, all counters=0, period-armed flag cleared.
REQ-021 Reset asserted mid-operation SHALL take effect at the next edge regardless of state; first change comparison after reset uses prev=0 (so a non-zero input yields trig0[0]=1).

Structure
REQ-022 Package seg7_ila_pkg SHALL hold data/trig0 field bit positions, TS width (16), and FAULT_LIMIT default.
REQ-023 Sub-module sync_edge (2-flop sync + rising-edge detect, 1 bit) SHALL be instantiated per btn bit; all else inline.
REQ-024 Output ports SHALL connect directly to ila_4kx32 data/trig0 with no glue logic.

Verification
REQ-025 Reset, then seg_an=4'hE, seg_cat=8'hC0 held -> data[15:0]=16'h0EC0 two cycles later, trig0[0]=1 once, trig0[15:8]=1.
REQ-026 Drive btn[2] 0->1 -> trig0[6]=1 and trig0[1]=1 for exactly one cycle, btn field = 4'h4 thereafter.
REQ-027 Rotate seg_an E,D,B,7 every 250 cycles -> after second digit-0 event trig0[31:16]=1000, updated every 1000 cycles.
REQ-028 Hold seg_an=4'h0 with FAULT_LIMIT=16 -> trig0[2] asserts after 16 illegal cycles, clears one cycle after seg_an=4'hF.
REQ-029 Run 65536 cycles -> trig0[3]=1 on single word with data[31:16]=0000; assert rst mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/seg7_ila_pkg.sv
// seg7_ila_pkg -- shared definitions for the 7-segment ILA probe.
//   cap_word_t : layout of the 32-bit ILA capture word (data port)
//   TRG_*      : bit positions of the fields in the trig0 vector
//   an_legal() : anode scan pattern check (one digit driven, or blank)
package seg7_ila_pkg;

  localparam int unsigned TS_W            = 16;
  localparam int unsigned FAULT_LIMIT_DEF = 1024;

  // Capture word, MSB first: {ts, btn_s, an, cat}
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [3:0]      btn;
    logic [3:0]      an;
    logic [7:0]      cat;
  } cap_word_t;

  // trig0 field map
  localparam int TRG_CHG      = 0;   // capture word differs from previous
  localparam int TRG_BTN_ANY  = 1;   // any button rising edge
  localparam int TRG_FAULT    = 2;   // anode scan fault (level)
  localparam int TRG_WRAP     = 3;   // timestamp wrapped FFFF->0000
  localparam int TRG_RISE_LSB = 4;   // [7:4] per-button rising edge
  localparam int TRG_CCNT_LSB = 8;   // [15:8] change event count
  localparam int TRG_PER_LSB  = 16;  // [31:16] digit-0 scan period

  // Active-low anodes: legal when exactly one digit is selected or all off.
  function automatic logic an_legal(input logic [3:0] an);
    case (an)
      4'hF, 4'hE, 4'hD, 4'hB, 4'h7: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- 2-flop synchronizer with rising-edge detect for one bit.
//   clk  : clock          rst  : synchronous active-high reset
//   d    : async input    q    : synchronized level
//   rise : q rose this cycle (q & ~q_prev), combinational off registers
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;

endmodule

// File: rtl/seg7_ila_probe.sv
// seg7_ila_probe -- formats 7-segment display and button activity into an
// ILA capture word plus a trigger vector.
//   clk, rst : clock, synchronous active-high reset
//   seg_an   : anode selects (active low), seg_cat : cathodes {dp,g..a}
//   btn      : raw push-buttons (asynchronous)
//   data     : {ts, btn_s, an, cat}, registered
//   trig0    : {period, chg_cnt, rise[3:0], wrap, fault, btn_any, chg}, registered
// Pipeline: seg -> s1 register -> data/trig0. Buttons go through a 2-flop
// synchronizer first, so they reach data one cycle after seg would.
module seg7_ila_probe
  import seg7_ila_pkg::*;
#(
  parameter int unsigned FAULT_LIMIT = FAULT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_an,
  input  logic [7:0]  seg_cat,
  input  logic [3:0]  btn,
  output logic [31:0] data,
  output logic [31:0] trig0
);

  localparam logic [15:0] FAULT_LIM = 16'(FAULT_LIMIT);

  logic [3:0]      an_s1, an_prev;
  logic [7:0]      cat_s1, cat_prev;
  logic [TS_W-1:0] ts;
  logic [15:0]     fault_cnt, fault_nxt, per_cnt;
  logic            armed;
  logic [3:0]      btn_s, rise;
  logic            chg, d0_evt, wrap;
  cap_word_t       cap_q;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (btn[i]),
      .q    (btn_s[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    chg       = {an_s1, cat_s1} != {an_prev, cat_prev};
    d0_evt    = an_prev[0] & ~an_s1[0];
    // Saturating run length of illegal scan patterns; any legal cycle clears it.
    fault_nxt = '0;
    if (!an_legal(an_s1))
      fault_nxt = (fault_cnt == 16'hFFFF) ? fault_cnt : fault_cnt + 16'd1;
    // Compare against the word currently on data so the first word after
    // reset (previous word forced to 0) can never flag a wrap.
    wrap      = (ts == '0) && (cap_q.ts == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1     <= '0;
      cat_s1    <= '0;
      an_prev   <= '0;
      cat_prev  <= '0;
      ts        <= '0;
      fault_cnt <= '0;
      per_cnt   <= '0;
      armed     <= 1'b0;
      cap_q     <= '0;
      trig0     <= '0;
    end else begin
      an_s1     <= seg_an;
      cat_s1    <= seg_cat;
      an_prev   <= an_s1;
      cat_prev  <= cat_s1;
      ts        <= ts + 1'b1;
      fault_cnt <= fault_nxt;

      cap_q <= '{ts: ts, btn: btn_s, an: an_s1, cat: cat_s1};

      trig0[TRG_CHG]               <= chg;
      trig0[TRG_BTN_ANY]           <= |rise;
      trig0[TRG_FAULT]             <= fault_nxt >= FAULT_LIM;
      trig0[TRG_WRAP]              <= wrap;
      trig0[TRG_RISE_LSB +: 4]     <= rise;
      trig0[TRG_CCNT_LSB +: 8]     <= trig0[TRG_CCNT_LSB +: 8] + 8'(chg);

      // Period measured between successive digit-0 selects; the first one
      // after reset only starts the count.
      if (d0_evt) begin
        per_cnt <= 16'd1;
        armed   <= 1'b1;
        if (armed) trig0[TRG_PER_LSB +: 16] <= per_cnt;
      end else if (per_cnt != 16'hFFFF) begin
        per_cnt <= per_cnt + 16'd1;
      end
    end
  end

  assign data = cap_q;

endmodule

// File: tb/tb_seg7_ila_probe.sv
// tb_seg7_ila_probe -- directed self-checking bench for seg7_ila_probe.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_ila_probe;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;
  logic [3:0]  btn;
  logic [31:0] data, trig0;

  int checks = 0;
  int errors = 0;
  int edges  = 0;  // rising edges since reset release

  always #5 clk = ~clk;

  seg7_ila_probe #(.FAULT_LIMIT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_an  (seg_an),
    .seg_cat (seg_cat),
    .btn     (btn),
    .data    (data),
    .trig0   (trig0)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      edges++;
    end
  endtask

  function automatic logic [15:0] exp_ts();
    return 16'(edges - 1);
  endfunction

  task automatic test_reset();
    logic [31:0] exp_d;
    rst = 1'b1; seg_an = 4'hE; seg_cat = 8'hC0; btn = 4'h0;
    step(3);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", data, 32'h0); end
    checks++; if (trig0 !== 32'h0) begin errors++; $display("FAIL reset_trig got %h exp %h", trig0, 32'h0); end
    rst = 1'b0; edges = 0;
    step(1);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL first_word got %h exp %h", data, 32'h0); end
    checks++; if (trig0 !== 32'h0) begin errors++; $display("FAIL first_trig got %h exp %h", trig0, 32'h0); end
    step(1);
    exp_d = {exp_ts(), 16'h0EC0};
    checks++; if (data !== exp_d) begin errors++; $display("FAIL seg_word got %h exp %h", data, exp_d); end
    checks++; if (trig0 !== 32'h0000_0101) begin errors++; $display("FAIL chg_pulse got %h exp %h", trig0, 32'h0000_0101); end
    step(1);
    checks++; if (trig0 !== 32'h0000_0100) begin errors++; $display("FAIL chg_once got %h exp %h", trig0, 32'h0000_0100); end
  endtask

  task automatic test_btn();
    logic [31:0] exp_d;
    btn = 4'h4;
    step(2);
    checks++; if (data[15:12] !== 4'h0) begin errors++; $display("FAIL btn_lat got %h exp %h", data[15:12], 4'h0); end
    checks++; if (trig0[7:0] !== 8'h00) begin errors++; $display("FAIL btn_early got %h exp %h", trig0[7:0], 8'h00); end
    step(1);
    exp_d = {exp_ts(), 16'h4EC0};
    checks++; if (data !== exp_d) begin errors++; $display("FAIL btn_word got %h exp %h", data, exp_d); end
    checks++; if (trig0[7:0] !== 8'h42) begin errors++; $display("FAIL btn_rise got %h exp %h", trig0[7:0], 8'h42); end
    step(1);
    checks++; if (trig0[7:0] !== 8'h00) begin errors++; $display("FAIL btn_pulse got %h exp %h", trig0[7:0], 8'h00); end
    checks++; if (data[15:12] !== 4'h4) begin errors++; $display("FAIL btn_hold got %h exp %h", data[15:12], 4'h4); end
    btn = 4'h0;
    step(4);
    checks++; if (trig0[7:0] !== 8'h00) begin errors++; $display("FAIL btn_fall got %h exp %h", trig0[7:0], 8'h00); end
  endtask

  task automatic test_period();
    logic [3:0] seq [4];
    seq[0] = 4'hD; seq[1] = 4'hB; seq[2] = 4'h7; seq[3] = 4'hE;
    // first rotation: final E arms the measurement
    for (int k = 0; k < 4; k++) begin seg_an = seq[k]; step(250); end
    checks++; if (trig0[31:16] !== 16'd0) begin errors++; $display("FAIL per_arm got %0d exp %0d", trig0[31:16], 0); end
    checks++; if (trig0[15:8] !== 8'd5) begin errors++; $display("FAIL chg_cnt5 got %0d exp %0d", trig0[15:8], 5); end
    for (int k = 0; k < 3; k++) begin seg_an = seq[k]; step(250); end
    seg_an = 4'hE;
    step(1);
    checks++; if (trig0 !== 32'h0000_0800) begin errors++; $display("FAIL per_pre got %h exp %h", trig0, 32'h0000_0800); end
    step(1);
    // period, change pulse and count all land in the same word
    checks++; if (trig0 !== 32'h03E8_0901) begin errors++; $display("FAIL per_1000 got %h exp %h", trig0, 32'h03E8_0901); end
    step(248);
    for (int k = 0; k < 2; k++) begin seg_an = seq[k]; step(250); end
    checks++; if (trig0[31:16] !== 16'd1000) begin errors++; $display("FAIL per_hold got %0d exp %0d", trig0[31:16], 1000); end
    seg_an = 4'h7; step(250);
    seg_an = 4'hE; step(2);
    checks++; if (trig0 !== 32'h03E8_0D01) begin errors++; $display("FAIL per_again got %h exp %h", trig0, 32'h03E8_0D01); end
    step(10);
  endtask

  task automatic test_fault();
    seg_an = 4'h0;
    step(16);
    checks++; if (trig0[2] !== 1'b0) begin errors++; $display("FAIL fault_15 got %b exp %b", trig0[2], 1'b0); end
    step(1);
    checks++; if (trig0 !== 32'h03E8_0E04) begin errors++; $display("FAIL fault_16 got %h exp %h", trig0, 32'h03E8_0E04); end
    step(5);
    checks++; if (trig0[2] !== 1'b1) begin errors++; $display("FAIL fault_lvl got %b exp %b", trig0[2], 1'b1); end
    seg_an = 4'hF;
    step(1);
    checks++; if (trig0[2] !== 1'b1) begin errors++; $display("FAIL fault_keep got %b exp %b", trig0[2], 1'b1); end
    step(1);
    checks++; if (trig0[2] !== 1'b0) begin errors++; $display("FAIL fault_clr got %b exp %b", trig0[2], 1'b0); end
    checks++; if (data[11:8] !== 4'hF) begin errors++; $display("FAIL fault_an got %h exp %h", data[11:8], 4'hF); end
  endtask

  task automatic test_wrap();
    // mid-run reset: previous outputs are non-zero
    rst = 1'b1;
    step(1);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp %h", data, 32'h0); end
    checks++; if (trig0 !== 32'h0) begin errors++; $display("FAIL midrst_trig got %h exp %h", trig0, 32'h0); end
    rst = 1'b0; edges = 0;
    step(1);
    checks++; if (data[31:16] !== 16'h0000 || trig0[3] !== 1'b0) begin
      errors++; $display("FAIL wrap_first got ts %h wrap %b exp ts 0000 wrap 0", data[31:16], trig0[3]); end
    step(65535 - edges + 1);
    checks++; if (data[31:16] !== 16'hFFFF || trig0[3] !== 1'b0) begin
      errors++; $display("FAIL wrap_pre got ts %h wrap %b exp ts ffff wrap 0", data[31:16], trig0[3]); end
    step(1);
    checks++; if (data[31:16] !== 16'h0000 || trig0[3] !== 1'b1) begin
      errors++; $display("FAIL wrap_hit got ts %h wrap %b exp ts 0000 wrap 1", data[31:16], trig0[3]); end
    step(1);
    checks++; if (data[31:16] !== 16'h0001 || trig0[3] !== 1'b0) begin
      errors++; $display("FAIL wrap_post got ts %h wrap %b exp ts 0001 wrap 0", data[31:16], trig0[3]); end
  endtask

  initial begin
    test_reset();
    test_btn();
    test_period();
    test_fault();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
